n_mac_ctrl: RTL

N_MAC_CTRL -- requirements
Module: n_mac_ctrl

---
 rtl/n_mac_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/n_mac_ctrl.sv
// n_mac_ctrl: issue controller for a MULT_LAT-deep float multiplier array.
// It reads operand beats from the buffers under downstream credit control and
// tracks in-flight beats with a valid shift register, so it can flag the final
// output beat and signal job completion.
// Optional feature: define MCTRL_ABORT_EN to add the abort input and the
// aborted output. The default build (macro undefined) has neither port.
module n_mac_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int LEN_W    = 16,
  parameter int CREDITS  = 8
) (
  input  logic             mult_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             credit_ret,
`ifdef MCTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             rd_en,
  output logic [LEN_W-1:0] rd_addr,
  output logic             out_vld,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  // Operand read adds one cycle ahead of the multiplier lanes.
  localparam int SR_N = MULT_LAT + 1;
  localparam int CW   = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]    CRED_MAX = CREDITS[CW-1:0];
  localparam logic [CW-1:0]    ONE_C    = 1;
  localparam logic [LEN_W-1:0] ONE_L    = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_addr;
  logic [CW-1:0]    r_credits;
  logic [SR_N-1:0]  r_vld_sr;
  logic [SR_N-1:0]  r_last_sr;
  logic             r_done;

  logic             w_abort;
  logic             w_issue_ok;
  logic             w_last_issue;
  logic             w_pipe_empty;

`ifdef MCTRL_ABORT_EN
  logic r_abort_job;
  logic r_aborted;

  // Abort only has meaning while beats are still being issued.
  assign w_abort = abort && (r_state == S_ISSUE);
`else
  assign w_abort = 1'b0;
`endif

  // A beat is issued whenever the job is issuing and a downstream slot is free.
  assign w_issue_ok   = (r_state == S_ISSUE) && (r_credits != '0) && !w_abort;
  assign w_last_issue = w_issue_ok && (r_addr == (r_len - ONE_L));
  // Everything but the output stage clear: after this edge the pipe is empty.
  assign w_pipe_empty = (r_vld_sr[SR_N-2:0] == '0);

  // Job sequencing: accept, issue, wait for in-flight beats, then report.
  always_ff @(posedge mult_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= '0;
            r_state <= (vec_len == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_abort) begin
            r_state <= S_DRAIN;
          end else if (w_issue_ok) begin
            r_addr <= r_addr + ONE_L;
            if (w_last_issue) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Job length is pure data: captured on acceptance, no reset needed.
  always_ff @(posedge mult_clk) begin
    if ((r_state == S_IDLE) && start) begin
      r_len <= vec_len;
    end
  end

  // Downstream slot accounting; a return while already full is dropped.
  always_ff @(posedge mult_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= CRED_MAX;
    end else begin
      case ({w_issue_ok, credit_ret})
        2'b10:   r_credits <= r_credits - ONE_C;
        2'b01:   if (r_credits != CRED_MAX) r_credits <= r_credits + ONE_C;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // In-flight tracking runs free of the FSM: every issued beat emerges.
  always_ff @(posedge mult_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr  <= '0;
      r_last_sr <= '0;
    end else begin
      r_vld_sr  <= {r_vld_sr[SR_N-2:0], w_issue_ok};
      r_last_sr <= {r_last_sr[SR_N-2:0], w_last_issue};
    end
  end

`ifdef MCTRL_ABORT_EN
  // Remember whether the current job was cut short.
  always_ff @(posedge mult_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abort_job <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_abort_job <= 1'b0;
    end else if (w_abort) begin
      r_abort_job <= 1'b1;
    end
  end

  // aborted is reported in the same cycle as the done pulse.
  always_ff @(posedge mult_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= (r_state == S_DONE) && r_abort_job;
    end
  end

  assign aborted = r_aborted;
`endif

  assign rd_en    = w_issue_ok;
  assign rd_addr  = r_addr;
  assign out_vld  = r_vld_sr[SR_N-1];
  assign out_last = r_last_sr[SR_N-1];
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

endmodule
